// File: rtl/cipher_stream_packer.sv
// cipher_stream_packer
// Host-side transmitter for the cipher core stream-in interface. It packs
// DW-bit host words, most significant slot first, into 128-bit blocks
// tagged with a 2-bit type. Each finished block is issued as a one-cycle
// vin pulse. ENC/DEC blocks wait for crypto_ready; KEY/IV blocks never wait.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   s_valid/ready : host word handshake
//   s_type        : 00 ENC, 01 DEC, 10 KEY, 11 IV
//   s_data        : host word; the first word lands in din[127:128-DW]
//   abort         : drop any partial or pending block
//   crypto_ready  : core ready status, only consulted for ENC/DEC blocks
//   vin/tin/din   : stream-in valid pulse, type and data
//   err_type      : sticky flag, type changed mid-block; err_clr clears it
//   blk_cnt       : blocks issued, wraps modulo 2^CW
module cipher_stream_packer #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [1:0]    s_type,
    input  logic [DW-1:0] s_data,
    input  logic          abort,
    input  logic          crypto_ready,
    output logic          vin,
    output logic [1:0]    tin,
    output logic [127:0]  din,
    output logic          err_type,
    input  logic          err_clr,
    output logic [CW-1:0] blk_cnt
);
    localparam int WORDS = 128 / DW;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [1:0]      r_type;
    logic [127:0]    r_buf;
    logic            r_ready;
    logic            r_vin;
    logic [1:0]      r_tin;
    logic [127:0]    r_din;
    logic            r_err;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_mismatch;
    logic [IW-1:0]   w_slot;
    logic            w_last;
    logic [1:0]      w_blk_type;
    logic            w_eligible;
    logic [127:0]    w_block;

    // Word accept decode and the block image with the incoming word merged in.
    always_comb begin
        // A word offered during abort is ignored.
        w_accept   = s_valid & r_ready & ~abort;
        w_mismatch = w_accept & (r_idx != IDX_ZERO) & (s_type != r_type);
        // A mismatching word restarts the block at slot 0.
        w_slot     = w_mismatch ? IDX_ZERO : r_idx;
        w_last     = w_accept & (w_slot == LAST_IDX);
        w_blk_type = (w_slot == IDX_ZERO) ? s_type : r_type;
        // KEY and IV (type bit 1 set) never wait for the core.
        w_eligible = w_blk_type[1] | crypto_ready;
        w_block    = r_buf;
        for (int k = 0; k < WORDS; k++) begin
            if (w_slot == IW'(k)) begin
                w_block[127 - k*DW -: DW] = s_data;
            end else begin
                w_block[127 - k*DW -: DW] = r_buf[127 - k*DW -: DW];
            end
        end
    end

    // Packer state machine with registered stream-in outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
            r_idx   <= IDX_ZERO;
            r_type  <= 2'b00;
            r_buf   <= 128'd0;
            r_ready <= 1'b0;
            r_vin   <= 1'b0;
            r_tin   <= 2'b00;
            r_din   <= 128'd0;
            r_err   <= 1'b0;
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_vin <= 1'b0;
            r_tin <= 2'b00;
            r_din <= 128'd0;

            // Set wins over a same-cycle clear.
            if (w_mismatch) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end

            case (r_state)
                ST_FILL: begin
                    r_ready <= 1'b1;
                    if (abort) begin
                        r_idx <= IDX_ZERO;
                    end else if (w_accept) begin
                        r_buf  <= w_block;
                        r_type <= w_blk_type;
                        if (w_last) begin
                            r_idx <= IDX_ZERO;
                            if (w_eligible) begin
                                r_vin <= 1'b1;
                                r_tin <= w_blk_type;
                                r_din <= w_block;
                                r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                            end else begin
                                r_state <= ST_WAIT;
                                r_ready <= 1'b0;
                            end
                        end else begin
                            r_idx <= w_slot + {{(IW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        r_state <= ST_FILL;
                        r_ready <= 1'b1;
                    end else if (crypto_ready) begin
                        r_state <= ST_FILL;
                        r_ready <= 1'b1;
                        r_vin   <= 1'b1;
                        r_tin   <= r_type;
                        r_din   <= r_buf;
                        r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                    r_idx   <= IDX_ZERO;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready  = r_ready;
    assign vin      = r_vin;
    assign tin      = r_tin;
    assign din      = r_din;
    assign err_type = r_err;
    assign blk_cnt  = r_cnt;

endmodule

// File: tb/tb_cipher_stream_packer.sv
// Testbench for cipher_stream_packer. Stimulus drives a queue-based model
// of the packer; completed blocks are pushed to a scoreboard and a monitor
// on the falling edge pops and compares them whenever vin is high.
// A second instance (DW=128, CW=4) exercises the counter wrap.
module tb_cipher_stream_packer;
    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int WORDS = 128 / DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [1:0]    s_type = 2'b00;
    logic [DW-1:0] s_data = '0;
    logic          abort = 1'b0;
    logic          crypto_ready = 1'b0;
    logic          vin;
    logic [1:0]    tin;
    logic [127:0]  din;
    logic          err_type;
    logic          err_clr = 1'b0;
    logic [CW-1:0] blk_cnt;

    logic          d2_valid = 1'b0;
    logic          d2_ready;
    logic [1:0]    d2_type = 2'b10;
    logic [127:0]  d2_data = '0;
    logic          d2_vin;
    logic [1:0]    d2_tin;
    logic [127:0]  d2_din;
    logic          d2_err;
    logic [3:0]    d2_cnt;

    cipher_stream_packer #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_type(s_type), .s_data(s_data), .abort(abort),
        .crypto_ready(crypto_ready), .vin(vin), .tin(tin), .din(din),
        .err_type(err_type), .err_clr(err_clr), .blk_cnt(blk_cnt)
    );

    cipher_stream_packer #(.DW(128), .CW(4)) dut2 (
        .clk(clk), .rst(rst), .s_valid(d2_valid), .s_ready(d2_ready),
        .s_type(d2_type), .s_data(d2_data), .abort(1'b0),
        .crypto_ready(1'b0), .vin(d2_vin), .tin(d2_tin), .din(d2_din),
        .err_type(d2_err), .err_clr(1'b0), .blk_cnt(d2_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [1:0]    t;
        logic [127:0]  d;
        logic [CW-1:0] c;
        int            at;
    } exp_t;
    exp_t sb[$];

    // Reference model state: words gathered so far and any held block.
    logic [DW-1:0] m_words[$];
    logic [1:0]    m_type = 2'b00;
    bit            m_pend = 1'b0;
    logic [127:0]  m_pblk = '0;
    logic [1:0]    m_ptype = 2'b00;
    bit            m_ready = 1'b0;
    bit            m_err = 1'b0;
    logic [CW-1:0] m_cnt = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic m_issue(input logic [1:0] t, input logic [127:0] d);
        exp_t e;
        m_cnt = m_cnt + CW'(1);
        e.t = t;
        e.d = d;
        e.c = m_cnt;
        e.at = cyc + 1;
        sb.push_back(e);
    endtask

    // Apply the current inputs to the model for the coming clock edge.
    task automatic m_step();
        bit mis;
        logic [127:0] blk;
        mis = 1'b0;
        if (!m_pend) begin
            if (abort) begin
                m_words.delete();
            end else if (s_valid && m_ready) begin
                if (m_words.size() > 0 && s_type != m_type) begin
                    mis = 1'b1;
                    m_words.delete();
                end
                if (m_words.size() == 0) m_type = s_type;
                m_words.push_back(s_data);
                if (m_words.size() == WORDS) begin
                    blk = '0;
                    foreach (m_words[i]) blk = (blk << DW) | 128'(m_words[i]);
                    m_words.delete();
                    if (m_type == 2'b10 || m_type == 2'b11 || crypto_ready) begin
                        m_issue(m_type, blk);
                    end else begin
                        m_pend  = 1'b1;
                        m_pblk  = blk;
                        m_ptype = m_type;
                    end
                end
            end
        end else begin
            if (abort) begin
                m_pend = 1'b0;
            end else if (crypto_ready) begin
                m_issue(m_ptype, m_pblk);
                m_pend = 1'b0;
            end
        end
        if (mis) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        m_ready = !m_pend;
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        cyc++;
        #1;
        check("s_ready", 128'(s_ready), 128'(m_ready));
        check("err_type", 128'(err_type), 128'(m_err));
        check("blk_cnt", 128'(blk_cnt), 128'(m_cnt));
    endtask

    task automatic send(input logic [1:0] t, input logic [DW-1:0] d);
        s_valid = 1'b1;
        s_type  = t;
        s_data  = d;
        tick();
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Scoreboard monitor: compares every vin pulse against the next expected block.
    always @(negedge clk) begin
        exp_t e;
        if (vin) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vin actual tin=%h din=%h required no block", tin, din);
            end else begin
                e = sb.pop_front();
                check("vin_tin", 128'(tin), 128'(e.t));
                check("vin_din", din, e.d);
                check("vin_cnt", 128'(blk_cnt), 128'(e.c));
                check("vin_cycle", 128'(cyc), 128'(e.at));
            end
        end else begin
            check("idle_din", din, 128'd0);
            check("idle_tin", 128'(tin), 128'd0);
        end
    end

    logic [1:0] cur_t;

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vin", 128'(vin), 128'd0);
        check("rst_din", din, 128'd0);
        check("rst_s_ready", 128'(s_ready), 128'd0);
        check("rst_err", 128'(err_type), 128'd0);
        check("rst_cnt", 128'(blk_cnt), 128'd0);
        rst = 1'b0;
        idle(1);
        check("ready_after_rst", 128'(s_ready), 128'd1);

        // KEY block, never held even with crypto_ready low.
        crypto_ready = 1'b0;
        send(2'b10, 32'h00010203);
        send(2'b10, 32'h04050607);
        send(2'b10, 32'h08090a0b);
        send(2'b10, 32'h0c0d0e0f);
        check("key_vin", 128'(vin), 128'd1);
        check("key_tin", 128'(tin), 128'd2);
        check("key_din", din, 128'h000102030405060708090a0b0c0d0e0f);
        check("key_cnt", 128'(blk_cnt), 128'd1);
        idle(1);

        // ENC block held until crypto_ready rises.
        for (int i = 0; i < WORDS; i++) send(2'b00, $urandom);
        idle(3);
        check("wait_ready", 128'(s_ready), 128'd0);
        check("wait_vin", 128'(vin), 128'd0);
        crypto_ready = 1'b1;
        tick();
        check("release_vin", 128'(vin), 128'd1);
        check("release_tin", 128'(tin), 128'd0);
        check("release_ready", 128'(s_ready), 128'd1);

        // Back-to-back DEC blocks; the monitor checks their cycle stamps.
        for (int i = 0; i < 2 * WORDS; i++) send(2'b01, $urandom);
        idle(2);

        // Type change mid-block drops the partial ENC block.
        send(2'b00, $urandom);
        send(2'b00, $urandom);
        send(2'b11, 32'h11111111);
        check("mismatch_err", 128'(err_type), 128'd1);
        send(2'b11, 32'h22222222);
        send(2'b11, 32'h33333333);
        send(2'b11, 32'h44444444);
        check("mismatch_iv_din", din, 128'h11111111222222223333333344444444);
        idle(1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", 128'(err_type), 128'd0);

        // Abort in FILL, word presented with abort is ignored.
        send(2'b00, 32'hdead0001);
        send(2'b00, 32'hdead0002);
        abort = 1'b1;
        send(2'b00, 32'hdead0003);
        abort = 1'b0;
        send(2'b00, 32'ha0a0a0a0);
        send(2'b00, 32'hb1b1b1b1);
        send(2'b00, 32'hc2c2c2c2);
        send(2'b00, 32'hd3d3d3d3);
        check("abort_fill_din", din, 128'ha0a0a0a0b1b1b1b1c2c2c2c2d3d3d3d3);
        idle(1);

        // Abort in WAIT drops the pending block.
        crypto_ready = 1'b0;
        for (int i = 0; i < WORDS; i++) send(2'b01, $urandom);
        idle(1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        crypto_ready = 1'b1;
        idle(3);
        check("abort_wait_ready", 128'(s_ready), 128'd1);

        // Randomised traffic.
        cur_t = 2'b00;
        for (int n = 0; n < 500; n++) begin
            s_valid = ($urandom_range(3, 0) != 0);
            if ($urandom_range(15, 0) == 0) cur_t = 2'($urandom_range(3, 0));
            s_type       = cur_t;
            s_data       = $urandom;
            abort        = ($urandom_range(31, 0) == 0);
            crypto_ready = ($urandom_range(1, 0) == 1);
            err_clr      = ($urandom_range(15, 0) == 0);
            tick();
        end
        abort = 1'b0;
        err_clr = 1'b0;
        crypto_ready = 1'b1;
        idle(3);
        check("sb_drained", 128'(sb.size()), 128'd0);

        // Asynchronous reset in the middle of a block.
        send(2'b10, $urandom);
        send(2'b10, $urandom);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_ready", 128'(s_ready), 128'd0);
        check("async_rst_cnt", 128'(blk_cnt), 128'd0);
        check("async_rst_err", 128'(err_type), 128'd0);
        check("async_rst_vin", 128'(vin), 128'd0);
        check("async_rst_din", din, 128'd0);
        m_words.delete();
        m_pend  = 1'b0;
        m_ready = 1'b0;
        m_err   = 1'b0;
        m_cnt   = '0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1 rst = 1'b0;
        idle(1);
        for (int i = 0; i < WORDS; i++) send(2'b10, $urandom);
        idle(2);

        // Counter wrap on the one-word-per-block instance.
        for (int i = 0; i < 17; i++) begin
            d2_valid = 1'b1;
            d2_data  = {$urandom, $urandom, $urandom, $urandom};
            tick();
            check("d2_vin", 128'(d2_vin), 128'd1);
            check("d2_din", d2_din, d2_data);
            check("d2_cnt", 128'(d2_cnt), 128'((i + 1) % 16));
        end
        d2_valid = 1'b0;
        idle(2);
        check("sb_final", 128'(sb.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
